ctrl_sequencer: RTL and testbench
=================================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 clock  input  1  rising-edge clock; sole clock domain.
REQ-002 clear  input  1  reset; synchronous, active-high.
REQ-003 start  input  1  request to run one accumulate sequence; sampled only in IDLE.
REQ-004 iter  input  3  number of add/write-back passes (0-7); latched when start is accepted.
REQ-005 RAin  output  1  load strobe for register A (immediate capture).
REQ-006 RBin  output  1  load strobe for register B (captures bus).
REQ-007 RZin  output  1  load strobe for register Z (captures adder result).
REQ-008 RAout  output  1  bus-drive enable, register A.
REQ-009 RBout  output  1  bus-drive enable, register B.
REQ-010 RZout  output  1  bus-drive enable, register Z.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have the states IDLE, LDA, AB, ADD, WB and DONE, held in a registered state vector; all outputs SHALL decode from state only (Moore).
REQ-014 IDLE: all strobes 0; start=1 -> LDA, latch iter into an internal 3-bit pass counter.
REQ-015 LDA: RAin=1 -> AB.
REQ-016 AB: RAout=1, RBin=1 (RB <= RA) -> ADD if counter != 0, else DONE.
REQ-017 ADD: RBout=1, RZin=1 (Z <= A + RB) -> WB.
REQ-018 WB: RZout=1, RBin=1 (RB <= Z); counter decrements; -> ADD if the decremented counter != 0, else DONE.
REQ-019 DONE: done=1, all strobes 0 -> IDLE.
REQ-020 Latency: with start accepted at edge 0, done SHALL be high in cycle 3+2*iter and busy SHALL return low in cycle 4+2*iter.
REQ-021 At most one of RAout/RBout/RZout SHALL be high in any cycle; RBout and RBin SHALL never be high together.
REQ-022 start while busy (including in DONE) SHALL be ignored, with no queuing; iter changes while busy SHALL have no effect.
REQ-023 iter=0 SHALL produce LDA, AB, DONE only; iter=7 SHALL produce exactly 7 ADD/WB pairs with no counter wrap.

Reset
REQ-024 clear=1 at a rising edge SHALL force IDLE and counter=0; in the following cycle all strobes, busy and done SHALL be 0.
REQ-025 clear SHALL take priority over start, and over abort when CTRL_SEQ_ABORT_EN is defined.
REQ-026 Reset mid-sequence SHALL abandon the sequence with no done pulse.

Configuration
REQ-027 Macro CTRL_SEQ_ABORT_EN: when defined, the module SHALL add the input abort (1 bit); abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and strobes low from the next cycle; abort SHALL be ignored in IDLE.
REQ-028 When CTRL_SEQ_ABORT_EN is undefined, the abort port and its logic SHALL be absent, and sequences SHALL always run to DONE unless clear is asserted.

Verification
REQ-029 Bench with the 8-bit datapath attached: A=5, immediate=3, iter=2, start pulse -> RB=13, done in cycle 7, busy low in cycle 8.
REQ-030 iter=0, immediate=9 -> strobe trace LDA, AB, DONE; RB=9; done in cycle 3; no RZin ever asserted.
REQ-031 iter=7, A=1, immediate=0 -> exactly 7 RZin pulses, RB=7, done in cycle 17.
REQ-032 start held high continuously with iter=1 -> back-to-back sequences separated by exactly one IDLE cycle; no start accepted during DONE.
REQ-033 clear asserted during the second ADD with iter=3 -> next cycle all outputs 0, no done pulse; a subsequent start runs a complete, correct sequence.
REQ-034 Assertion check every cycle: one-hot-or-zero on the *out strobes, and never RBout with RBin; with CTRL_SEQ_ABORT_EN, abort in WB -> IDLE next cycle with done=0.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: Moore control FSM that drives a three-register accumulate
// datapath (A, B, Z on a shared bus with an adder into Z).
// Sequence: IDLE -> LDA -> AB -> (ADD -> WB) x iter -> DONE -> IDLE.
//
// Ports:
//   clock                   rising-edge clock
//   clear                   synchronous active-high reset
//   start                   run request, sampled only in IDLE
//   iter[2:0]               number of ADD/WB passes, latched when start is accepted
//   abort                   (only with CTRL_SEQ_ABORT_EN) return to IDLE from any busy state
//   RAin/RBin/RZin          register load strobes
//   RAout/RBout/RZout       bus-drive enables
//   busy                    high in every state except IDLE
//   done                    one-cycle completion pulse
//
// Optional feature macro: CTRL_SEQ_ABORT_EN adds the abort input.
//
// All outputs are flops loaded from a decode of the next state, so they always
// equal the decode of the current state (pure Moore timing, glitch-free).

module ctrl_sequencer (
   input  logic       clock,
   input  logic       clear,
   input  logic       start,
   input  logic [2:0] iter,
`ifdef CTRL_SEQ_ABORT_EN
   input  logic       abort,
`endif
   output logic       RAin,
   output logic       RBin,
   output logic       RZin,
   output logic       RAout,
   output logic       RBout,
   output logic       RZout,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CNT_W = 3;
   localparam int unsigned OUT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LDA  = 3'd1,
      S_AB   = 3'd2,
      S_ADD  = 3'd3,
      S_WB   = 3'd4,
      S_DONE = 3'd5
   } state_e;

   // Output vector bit order: {RAin, RBin, RZin, RAout, RBout, RZout, busy, done}
   localparam logic [OUT_W-1:0] O_IDLE = 8'b0000_0000;
   localparam logic [OUT_W-1:0] O_LDA  = 8'b1000_0010;
   localparam logic [OUT_W-1:0] O_AB   = 8'b0101_0010;
   localparam logic [OUT_W-1:0] O_ADD  = 8'b0010_1010;
   localparam logic [OUT_W-1:0] O_WB   = 8'b0100_0110;
   localparam logic [OUT_W-1:0] O_DONE = 8'b0000_0011;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OUT_W-1:0]   out_q, out_d;

   // Next-state, pass counter and output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = O_IDLE;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LDA;
               cnt_d   = CNT_W'(iter);
            end
         end
         S_LDA:  state_d = S_AB;
         S_AB:   state_d = (cnt_q != '0) ? S_ADD : S_DONE;
         S_ADD:  state_d = S_WB;
         S_WB: begin
            // Loop decision uses the decremented count, so iter=N gives N passes
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = (cnt_d != '0) ? S_ADD : S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

`ifdef CTRL_SEQ_ABORT_EN
      // Abort abandons any running sequence; no DONE pulse is produced
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
`endif

      case (state_d)
         S_IDLE:  out_d = O_IDLE;
         S_LDA:   out_d = O_LDA;
         S_AB:    out_d = O_AB;
         S_ADD:   out_d = O_ADD;
         S_WB:    out_d = O_WB;
         S_DONE:  out_d = O_DONE;
         default: out_d = O_IDLE;
      endcase
   end

   // State, counter and output registers; clear wins over everything
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         out_q   <= O_IDLE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   assign RAin  = out_q[7];
   assign RBin  = out_q[6];
   assign RZin  = out_q[5];
   assign RAout = out_q[4];
   assign RBout = out_q[3];
   assign RZout = out_q[2];
   assign busy  = out_q[1];
   assign done  = out_q[0];

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with an 8-bit datapath model attached:
// RA captures an immediate, RB captures the bus, RZ captures a_v + bus.
module tb_ctrl_sequencer;

   localparam logic [7:0] C_IDLE = 8'b0000_0000;
   localparam logic [7:0] C_LDA  = 8'b1000_0010;
   localparam logic [7:0] C_AB   = 8'b0101_0010;
   localparam logic [7:0] C_ADD  = 8'b0010_1010;
   localparam logic [7:0] C_WB   = 8'b0100_0110;
   localparam logic [7:0] C_DONE = 8'b0000_0011;

   logic       clock;
   logic       clear;
   logic       start;
   logic [2:0] iter;
`ifdef CTRL_SEQ_ABORT_EN
   logic       abort;
`endif
   logic RAin, RBin, RZin, RAout, RBout, RZout, busy, done;

   int n_cmp;
   int n_bad;
   logic mon_en;

   // Datapath model
   logic [7:0] ra, rb, rz, a_v, imm_v, bus;
   logic [7:0] obs;

   // Results of the last run_seq
   int done_cyc, idle_cyc, rz_cnt, done_cnt;
   logic [7:0] trace [0:31];

   ctrl_sequencer dut (
      .clock (clock),
      .clear (clear),
      .start (start),
      .iter  (iter),
`ifdef CTRL_SEQ_ABORT_EN
      .abort (abort),
`endif
      .RAin  (RAin),
      .RBin  (RBin),
      .RZin  (RZin),
      .RAout (RAout),
      .RBout (RBout),
      .RZout (RZout),
      .busy  (busy),
      .done  (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign obs = {RAin, RBin, RZin, RAout, RBout, RZout, busy, done};

   always_comb begin
      if (RAout)      bus = ra;
      else if (RBout) bus = rb;
      else if (RZout) bus = rz;
      else            bus = 8'h00;
   end

   always @(posedge clock) begin
      if (RAin) ra <= imm_v;
      if (RBin) rb <= bus;
      if (RZin) rz <= a_v + bus;
   end

   // Every-cycle bus-safety check
   always @(negedge clock) begin
      if (mon_en) begin
         n_cmp++;
         if (($countones({RAout, RBout, RZout}) > 1) || (RBout && RBin)) begin
            n_bad++;
            $display("FAIL bus_safety t=%0t out={RA,RB,RZ}=%b RBin=%b required one-hot-or-zero and not RBout&RBin",
                     $time, {RAout, RBout, RZout}, RBin);
         end
      end
   end

   // Start one sequence at edge 0 and record cycles 1..budget (cycle k = after edge k-1... sampled at negedge)
   task automatic run_seq(input logic [7:0] imm, input logic [7:0] a, input logic [2:0] it, input int budget);
      @(negedge clock);
      imm_v = imm; a_v = a; iter = it; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      iter  = ~it;
      done_cyc = -1; idle_cyc = -1; rz_cnt = 0; done_cnt = 0;
      for (int c = 1; c <= budget; c++) begin
         if (c < 32) trace[c] = obs;
         if (RZin) rz_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (!busy) begin
            idle_cyc = c;
            break;
         end
         // A start pulse mid-sequence must be ignored
         start = (c == 2);
         @(negedge clock);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      clear = 1'b1; start = 1'b0; iter = 3'd0;
`ifdef CTRL_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      imm_v = 8'h00; a_v = 8'h00;
      repeat (3) @(negedge clock);
      n_cmp++;
      if (obs !== C_IDLE) begin
         n_bad++;
         $display("FAIL reset_outputs got=%b required=%b", obs, C_IDLE);
      end
      clear = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (obs !== C_IDLE) begin
         n_bad++;
         $display("FAIL reset_idle got=%b required=%b", obs, C_IDLE);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_accumulate();
      run_seq(8'd3, 8'd5, 3'd2, 40);
      n_cmp++; if (rb !== 8'd13)   begin n_bad++; $display("FAIL acc_rb got=%0d required=13", rb); end
      n_cmp++; if (done_cyc != 7)  begin n_bad++; $display("FAIL acc_done_cycle got=%0d required=7", done_cyc); end
      n_cmp++; if (idle_cyc != 8)  begin n_bad++; $display("FAIL acc_idle_cycle got=%0d required=8", idle_cyc); end
      n_cmp++; if (done_cnt != 1)  begin n_bad++; $display("FAIL acc_done_count got=%0d required=1", done_cnt); end
      n_cmp++; if (rz_cnt != 2)    begin n_bad++; $display("FAIL acc_rzin_count got=%0d required=2", rz_cnt); end
      n_cmp++; if (trace[1] !== C_LDA) begin n_bad++; $display("FAIL acc_trace_lda got=%b required=%b", trace[1], C_LDA); end
      n_cmp++; if (trace[3] !== C_ADD) begin n_bad++; $display("FAIL acc_trace_add got=%b required=%b", trace[3], C_ADD); end
      n_cmp++; if (trace[4] !== C_WB)  begin n_bad++; $display("FAIL acc_trace_wb got=%b required=%b", trace[4], C_WB); end
      n_cmp++; if (trace[6] !== C_WB)  begin n_bad++; $display("FAIL acc_trace_wb2 got=%b required=%b", trace[6], C_WB); end
   endtask

   task automatic test_iter_zero();
      run_seq(8'd9, 8'd5, 3'd0, 40);
      n_cmp++; if (trace[1] !== C_LDA)  begin n_bad++; $display("FAIL it0_trace_lda got=%b required=%b", trace[1], C_LDA); end
      n_cmp++; if (trace[2] !== C_AB)   begin n_bad++; $display("FAIL it0_trace_ab got=%b required=%b", trace[2], C_AB); end
      n_cmp++; if (trace[3] !== C_DONE) begin n_bad++; $display("FAIL it0_trace_done got=%b required=%b", trace[3], C_DONE); end
      n_cmp++; if (rb !== 8'd9)   begin n_bad++; $display("FAIL it0_rb got=%0d required=9", rb); end
      n_cmp++; if (done_cyc != 3) begin n_bad++; $display("FAIL it0_done_cycle got=%0d required=3", done_cyc); end
      n_cmp++; if (rz_cnt != 0)   begin n_bad++; $display("FAIL it0_rzin_count got=%0d required=0", rz_cnt); end
   endtask

   task automatic test_iter_max();
      run_seq(8'd0, 8'd1, 3'd7, 60);
      n_cmp++; if (rz_cnt != 7)    begin n_bad++; $display("FAIL it7_rzin_count got=%0d required=7", rz_cnt); end
      n_cmp++; if (rb !== 8'd7)    begin n_bad++; $display("FAIL it7_rb got=%0d required=7", rb); end
      n_cmp++; if (done_cyc != 17) begin n_bad++; $display("FAIL it7_done_cycle got=%0d required=17", done_cyc); end
      n_cmp++; if (idle_cyc != 18) begin n_bad++; $display("FAIL it7_idle_cycle got=%0d required=18", idle_cyc); end
   endtask

   task automatic test_back_to_back();
      // iter=1: LDA AB ADD WB DONE IDLE, repeating with start held high
      logic [11:0] exp_busy, exp_done, got_busy, got_done;
      exp_busy = 12'b0111_1101_1111; // bit k-1 = cycle k
      exp_done = 12'b0100_0001_0000;
      got_busy = '0; got_done = '0;
      @(negedge clock);
      imm_v = 8'd1; a_v = 8'd2; iter = 3'd1; start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         got_busy[c-1] = busy;
         got_done[c-1] = done;
      end
      start = 1'b0;
      n_cmp++; if (got_busy !== exp_busy) begin n_bad++; $display("FAIL b2b_busy got=%b required=%b", got_busy, exp_busy); end
      n_cmp++; if (got_done !== exp_done) begin n_bad++; $display("FAIL b2b_done got=%b required=%b", got_done, exp_done); end
      n_cmp++; if (rb !== 8'd3) begin n_bad++; $display("FAIL b2b_rb got=%0d required=3", rb); end
      @(negedge clock);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_stop got=%b required=0", busy); end
   endtask

   task automatic test_clear_mid();
      int extra_done;
      @(negedge clock);
      imm_v = 8'd2; a_v = 8'd4; iter = 3'd3; start = 1'b1;
      @(negedge clock);      // cycle 1
      start = 1'b0;
      repeat (4) @(negedge clock); // cycle 5 = second ADD
      n_cmp++; if (obs !== C_ADD) begin n_bad++; $display("FAIL clr_pre_add got=%b required=%b", obs, C_ADD); end
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      n_cmp++; if (obs !== C_IDLE) begin n_bad++; $display("FAIL clr_outputs got=%b required=%b", obs, C_IDLE); end
      extra_done = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (done || busy) extra_done++;
      end
      n_cmp++; if (extra_done != 0) begin n_bad++; $display("FAIL clr_no_done got=%0d required=0", extra_done); end
      run_seq(8'd2, 8'd4, 3'd3, 40);
      n_cmp++; if (rb !== 8'd14)  begin n_bad++; $display("FAIL clr_rerun_rb got=%0d required=14", rb); end
      n_cmp++; if (done_cyc != 9) begin n_bad++; $display("FAIL clr_rerun_done got=%0d required=9", done_cyc); end
   endtask

   task automatic test_clear_priority();
      @(negedge clock);
      iter = 3'd2; clear = 1'b1; start = 1'b1;
      @(negedge clock);
      clear = 1'b0; start = 1'b0;
      n_cmp++; if (obs !== C_IDLE) begin n_bad++; $display("FAIL clrpri_outputs got=%b required=%b", obs, C_IDLE); end
      @(negedge clock);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clrpri_busy got=%b required=0", busy); end
   endtask

`ifdef CTRL_SEQ_ABORT_EN
   task automatic test_abort();
      int extra;
      @(negedge clock);
      imm_v = 8'd1; a_v = 8'd1; iter = 3'd2; start = 1'b1;
      @(negedge clock);      // cycle 1
      start = 1'b0;
      repeat (3) @(negedge clock); // cycle 4 = WB
      n_cmp++; if (obs !== C_WB) begin n_bad++; $display("FAIL abort_pre_wb got=%b required=%b", obs, C_WB); end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      n_cmp++; if (obs !== C_IDLE) begin n_bad++; $display("FAIL abort_outputs got=%b required=%b", obs, C_IDLE); end
      extra = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         if (done || busy) extra++;
      end
      n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL abort_no_done got=%0d required=0", extra); end
      // Abort in IDLE is ignored
      abort = 1'b1; start = 1'b1;
      @(negedge clock);
      abort = 1'b0; start = 1'b0;
      n_cmp++; if (obs !== C_LDA) begin n_bad++; $display("FAIL abort_idle_ignored got=%b required=%b", obs, C_LDA); end
      repeat (8) @(negedge clock);
   endtask
`endif

   initial begin
      n_cmp = 0; n_bad = 0; mon_en = 1'b0;
      test_reset();
      test_accumulate();
      test_iter_zero();
      test_iter_max();
      test_back_to_back();
      test_clear_mid();
      test_clear_priority();
`ifdef CTRL_SEQ_ABORT_EN
      test_abort();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
